// File: rtl/ph_write_sched_pkg.sv
// Shared definitions for the parasite-to-host Tube write scheduler.
package ph_write_sched_pkg;

  localparam int unsigned NCH = 4;

  localparam logic [1:0] CH_R1 = 2'd0;
  localparam logic [1:0] CH_R2 = 2'd1;
  localparam logic [1:0] CH_R3 = 2'd2;
  localparam logic [1:0] CH_R4 = 2'd3;

  localparam int unsigned GUARD_SLOTS_DEF = 2;

  // Counter width able to hold the guard load value (at least one bit).
  function automatic int unsigned guard_width(input int unsigned slots);
    return (slots < 1) ? 1 : $clog2(slots + 1);
  endfunction

  localparam int unsigned GUARD_W = guard_width(GUARD_SLOTS_DEF);

  typedef enum logic {
    S_WRITE = 1'b0,
    S_IDLE  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/ph_write_sched_if.sv
// Requester handshake plus FIFO-quad write port of the write scheduler.
interface ph_write_sched_if
  import ph_write_sched_pkg::*;
  ();

  logic [NCH-1:0]   req_valid;
  logic [8*NCH-1:0] req_data;
  logic [NCH-1:0]   req_ready;
  logic [NCH-1:0]   p_full;
  logic [7:0]       p_data;
  logic [NCH-1:0]   p_selectData;
  logic             p_rdnw;
  logic             busy;

  modport slave (
    input  req_valid, req_data, p_full,
    output req_ready, p_data, p_selectData, p_rdnw, busy
  );

  modport master (
    output req_valid, req_data, p_full,
    input  req_ready, p_data, p_selectData, p_rdnw, busy
  );

endinterface

// File: rtl/ph_write_sched_rr_arb4.sv
// 4-way round-robin picker with optional fixed priority for channel 3.
module ph_rr_arb4
  import ph_write_sched_pkg::*;
(
  input  logic [NCH-1:0] eligible,
  input  logic [1:0]     ptr,
  input  logic           prio_en,
  output logic [NCH-1:0] grant,
  output logic [1:0]     grant_idx,
  output logic           grant_valid
);

  logic [1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    if (prio_en && eligible[CH_R4]) begin
      grant_idx   = CH_R4;
      grant_valid = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        idx = ptr + 2'(k);
        if (!grant_valid && eligible[idx]) begin
          grant_idx   = idx;
          grant_valid = 1'b1;
        end
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/ph_write_sched.sv
// Parasite-side scheduler: one write per p_phi2_en slot into the parasite-to-host FIFO quad.
module ph_write_sched
  import ph_write_sched_pkg::*;
#(
  parameter int unsigned GUARD_SLOTS = GUARD_SLOTS_DEF,
  parameter bit          R4_PRIORITY = 1'b1
) (
  input  logic               p_phi2,
  input  logic               p_rst,
  input  logic               p_phi2_en,
  ph_write_sched_if.slave    bus
);

  localparam int unsigned GW = guard_width(GUARD_SLOTS);

  slot_state_t            state;
  logic [NCH-1:0][GW-1:0] guard;
  logic [1:0]             rr_ptr;
  logic [NCH-1:0]         sel_q;
  logic [7:0]             data_q;

  logic [NCH-1:0] eligible;
  logic [NCH-1:0] grant;
  logic [1:0]     grant_idx;
  logic           grant_valid;
  logic           preempt;

  // Scheduling is only evaluated on enable clocks, so eligibility is masked there.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      eligible[i] = p_phi2_en & bus.req_valid[i] & ~bus.p_full[i] & (guard[i] == '0);
    end
  end

  assign preempt = R4_PRIORITY && eligible[CH_R4];

  ph_rr_arb4 u_arb (
    .eligible    (eligible),
    .ptr         (rr_ptr),
    .prio_en     (R4_PRIORITY),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge p_phi2) begin
    if (p_rst) begin
      state  <= S_IDLE;
      guard  <= '0;
      rr_ptr <= '0;
      sel_q  <= '0;
      data_q <= '0;
    end else if (p_phi2_en) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (grant_valid && (grant_idx == 2'(i))) guard[i] <= GW'(GUARD_SLOTS);
        else if (guard[i] != '0)                 guard[i] <= guard[i] - 1'b1;
      end
      if (grant_valid) begin
        state  <= S_WRITE;
        sel_q  <= grant;
        data_q <= bus.req_data[{grant_idx, 3'b000} +: 8];
        if (!preempt) rr_ptr <= grant_idx + 2'd1;
      end else begin
        state <= S_IDLE;
        sel_q <= '0;
      end
    end
  end

  assign bus.req_ready    = grant;
  assign bus.p_selectData = sel_q;
  assign bus.p_data       = data_q;
  assign bus.p_rdnw       = (state == S_IDLE);
  assign bus.busy         = (|guard) | (state == S_WRITE);

endmodule

// File: tb/tb_ph_write_sched.sv
// Directed bench for ph_write_sched: vector table plus hand-written multi-cycle sequences.
module tb_ph_write_sched;
  import ph_write_sched_pkg::*;

  logic p_phi2 = 1'b0;
  logic p_rst;
  logic p_phi2_en;

  ph_write_sched_if bus ();

  ph_write_sched #(
    .GUARD_SLOTS (2),
    .R4_PRIORITY (1'b1)
  ) dut (
    .p_phi2    (p_phi2),
    .p_rst     (p_rst),
    .p_phi2_en (p_phi2_en),
    .bus       (bus)
  );

  always #5 p_phi2 = ~p_phi2;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       en;
    logic [3:0] valid;
    logic [3:0] full;
    logic [3:0] ready;
    logic [3:0] sel;
    logic [7:0] data;
    logic       rdnw;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one clock's inputs at the falling edge, check req_ready, then step past the rising edge.
  task automatic apply(input logic en, input logic [3:0] v, input logic [3:0] f,
                       input logic [3:0] exp_rdy, input string nm);
    @(negedge p_phi2);
    p_phi2_en     = en;
    bus.req_valid = v;
    bus.p_full    = f;
    #1;
    check({nm, " req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    @(posedge p_phi2);
    #1;
  endtask

  task automatic port(input string nm, input logic [3:0] sel, input logic [7:0] data,
                      input logic rdnw, input logic busy);
    check({nm, " p_selectData"}, 32'(bus.p_selectData), 32'(sel));
    check({nm, " p_data"},       32'(bus.p_data),       32'(data));
    check({nm, " p_rdnw"},       32'(bus.p_rdnw),       32'(rdnw));
    check({nm, " busy"},         32'(bus.busy),         32'(busy));
  endtask

  initial begin
    p_rst         = 1'b1;
    p_phi2_en     = 1'b1;
    bus.req_valid = '0;
    bus.p_full    = '0;
    // R4=5A, R3=C3, R2=3C, R1=A5
    bus.req_data  = {8'h5A, 8'hC3, 8'h3C, 8'hA5};

    repeat (2) @(posedge p_phi2);
    #1;
    check("reset req_ready", 32'(bus.req_ready), 32'h0);
    port("reset", 4'b0000, 8'h00, 1'b1, 1'b0);
    @(negedge p_phi2);
    p_rst = 1'b0;

    //                en    valid    full     ready    sel      data   rdnw  busy
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0011, 4'b0000, 4'b0001, 4'b0001, 8'hA5, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'b0011, 4'b0000, 4'b0010, 4'b0010, 8'h3C, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 8'h3C, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 4'b0011, 4'b0000, 4'b0001, 4'b0001, 8'hA5, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'b0011, 4'b0000, 4'b0010, 4'b0010, 8'h3C, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h3C, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h3C, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 8'h3C, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 8'h3C, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 8'hC3, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'hC3, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'hC3, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 8'hC3, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 8'h3C, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h3C, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h3C, 1'b1, 1'b0});

    foreach (vecs[i]) begin
      apply(vecs[i].en, vecs[i].valid, vecs[i].full, vecs[i].ready, $sformatf("vec%0d", i));
      port($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].rdnw, vecs[i].busy);
    end

    // R4 pre-emption: move rr_ptr to 1, then each requester offers one byte and drops valid once taken.
    apply(1'b1, 4'b0001, 4'b0000, 4'b0001, "prio setup");
    port("prio setup", 4'b0001, 8'hA5, 1'b0, 1'b1);
    apply(1'b1, 4'b1111, 4'b0000, 4'b1000, "prio g1");
    port("prio g1", 4'b1000, 8'h5A, 1'b0, 1'b1);
    apply(1'b1, 4'b0111, 4'b0000, 4'b0010, "prio g2");
    port("prio g2", 4'b0010, 8'h3C, 1'b0, 1'b1);
    apply(1'b1, 4'b0101, 4'b0000, 4'b0100, "prio g3");
    port("prio g3", 4'b0100, 8'hC3, 1'b0, 1'b1);
    apply(1'b1, 4'b0001, 4'b0000, 4'b0001, "prio g4");
    port("prio g4", 4'b0001, 8'hA5, 1'b0, 1'b1);

    // Sparse enables: ready only on the enable clock, port holds between slots.
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 4'b0010, 4'b0000, 4'b0000, $sformatf("sparse pre%0d", k));
      port($sformatf("sparse pre%0d", k), 4'b0001, 8'hA5, 1'b0, 1'b1);
    end
    apply(1'b1, 4'b0010, 4'b0000, 4'b0010, "sparse grant");
    port("sparse grant", 4'b0010, 8'h3C, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 4'b0000, 4'b0000, 4'b0000, $sformatf("sparse hold%0d", k));
      port($sformatf("sparse hold%0d", k), 4'b0010, 8'h3C, 1'b0, 1'b1);
    end
    apply(1'b1, 4'b0000, 4'b0000, 4'b0000, "sparse idle");
    port("sparse idle", 4'b0000, 8'h3C, 1'b1, 1'b1);

    // Reset right after a grant abandons the write; the held request is served again afterwards.
    apply(1'b1, 4'b1000, 4'b0000, 4'b1000, "rst grant");
    port("rst grant", 4'b1000, 8'h5A, 1'b0, 1'b1);
    p_rst = 1'b1;
    apply(1'b1, 4'b1000, 4'b0000, 4'b0000, "rst cycle");
    port("rst cycle", 4'b0000, 8'h00, 1'b1, 1'b0);
    p_rst = 1'b0;
    apply(1'b1, 4'b1000, 4'b0000, 4'b1000, "rst regrant");
    port("rst regrant", 4'b1000, 8'h5A, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
